// File: rtl/rr_reg_arbiter.sv
// Round-robin writer arbitration onto one shared register; 1-cycle latency, no backpressure (losers re-arbitrate).
// Optional RRARB_LOCK_EN adds per-requester ownership hold with forced release after MAX_LOCK repeats.
module rr_reg_arbiter #(
  parameter int N        = 4,
  parameter int W        = 8,
  parameter int MAX_LOCK = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
`ifdef RRARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           q_vld
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  if (N < 2 || W < 1 || MAX_LOCK < 1) begin : g_bad_param
    $error("rr_reg_arbiter: N must be >= 2, W and MAX_LOCK >= 1");
  end

  logic [PW-1:0] ptr;
  logic [PW-1:0] rr_win;
  logic [PW-1:0] sel;
  logic          lock_hit;

  // Circular search from ptr; first pending requester wins.
  always_comb begin
    int  idx;
    logic found;
    idx    = 0;
    found  = 1'b0;
    rr_win = ptr;
    for (int i = 0; i < N; i++) begin
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found  = 1'b1;
        rr_win = PW'(idx);
      end
    end
  end

`ifdef RRARB_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK + 1);

  logic [CW-1:0] lock_cnt;
  logic [PW-1:0] last;

  // ptr always sits one past the last winner, so the previous owner is ptr-1.
  assign last     = (ptr == '0) ? PW'(N - 1) : ptr - PW'(1);
  assign lock_hit = (|gnt) && req[last] && lock[last] && (lock_cnt < CW'(MAX_LOCK));
  assign sel      = lock_hit ? last : rr_win;

  always_ff @(posedge clk) begin
    if (!rst) begin
      lock_cnt <= '0;
    end else if (lock_hit) begin
      lock_cnt <= lock_cnt + CW'(1);
    end else begin
      lock_cnt <= '0;
    end
  end
`else
  assign lock_hit = 1'b0;
  assign sel      = rr_win;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      gnt   <= '0;
      q     <= '0;
      q_vld <= 1'b0;
      ptr   <= '0;
    end else if (|req) begin
      gnt   <= N'(1) << sel;
      q     <= wdata[sel*W +: W];
      q_vld <= 1'b1;
      if (!lock_hit) begin
        ptr <= (rr_win == PW'(N - 1)) ? '0 : rr_win + PW'(1);
      end
    end else begin
      gnt   <= '0;
      q_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_reg_arbiter.sv
// Directed and random checks of rr_reg_arbiter against a scoreboard fed by a behavioural model.
module tb_rr_reg_arbiter;
  localparam int N        = 4;
  localparam int W        = 8;
  localparam int MAX_LOCK = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
`ifdef RRARB_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           q_vld;

  typedef struct packed {
    logic [N-1:0] g;
    logic [W-1:0] d;
    logic         v;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         m_ptr  = 0;
  int         m_last = 0;
  int         m_cnt  = 0;
  bit         m_hasg = 1'b0;
  logic [W-1:0] m_q  = '0;

  rr_reg_arbiter #(.N(N), .W(W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .wdata (wdata),
`ifdef RRARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .q     (q),
    .q_vld (q_vld)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: model predicts the post-edge outputs, scoreboard compares them.
  task automatic step(input logic r, input logic [N-1:0] rq);
    exp_t e;
    exp_t got;
    int   w;
    rst = r;
    req = rq;
    w   = -1;
    if (!r) begin
      m_ptr = 0; m_cnt = 0; m_hasg = 1'b0; m_q = '0;
      e = '{g: '0, d: '0, v: 1'b0};
    end else if (rq == '0) begin
      m_cnt = 0; m_hasg = 1'b0;
      e = '{g: '0, d: m_q, v: 1'b0};
    end else begin
`ifdef RRARB_LOCK_EN
      if (m_hasg && rq[m_last] && lock[m_last] && m_cnt < MAX_LOCK) begin
        w = m_last;
        m_cnt++;
      end
`endif
      if (w < 0) begin
        for (int i = 0; i < N; i++)
          if (w < 0 && rq[(m_ptr + i) % N]) w = (m_ptr + i) % N;
        m_ptr = (w + 1) % N;
        m_cnt = 0;
      end
      m_last = w;
      m_hasg = 1'b1;
      m_q    = wdata[w*W +: W];
      e      = '{g: N'(1) << w, d: m_q, v: 1'b1};
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    check("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
    if (sbq.size() != 0) begin
      got = sbq.pop_front();
      check("sb_gnt", 32'(gnt), 32'(got.g));
      check("sb_q", 32'(q), 32'(got.d));
      check("sb_q_vld", 32'(q_vld), 32'(got.v));
    end
  endtask

  task automatic set_words(input logic [W-1:0] base);
    for (int i = 0; i < N; i++) wdata[i*W +: W] = base + W'(i);
  endtask

  initial begin
    rst   = 1'b0;
    req   = '0;
    wdata = '0;
`ifdef RRARB_LOCK_EN
    lock  = '0;
`endif
    #1;

    // Reset overrides pending requests
    set_words(8'h30);
    step(1'b0, 4'b1111);
    step(1'b0, 4'b1111);
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_q_vld", 32'(q_vld), 32'h0);
    step(1'b1, 4'b1111);
    check("first_gnt", 32'(gnt), 32'h1);
    check("first_q", 32'(q), 32'h30);

    // Single requester, then idle holds q
    wdata[2*W +: W] = 8'hA5;
    step(1'b1, 4'b0100);
    check("single_gnt", 32'(gnt), 32'h4);
    check("single_q", 32'(q), 32'hA5);
    step(1'b1, 4'b0000);
    check("idle_gnt", 32'(gnt), 32'h0);
    check("idle_q_hold", 32'(q), 32'hA5);
    check("idle_q_vld", 32'(q_vld), 32'h0);

    // Full rotation from ptr=0
    step(1'b0, 4'b0000);
    set_words(8'h10);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 4'b1111);
      check("rot_gnt", 32'(gnt), 32'(1 << (i % 4)));
      check("rot_q", 32'(q), 32'(8'h10 + i % 4));
    end

    // Wrap past requester 3 and skip idle requesters
    step(1'b1, 4'b0101);
    check("wrap_gnt0", 32'(gnt), 32'h1);
    step(1'b1, 4'b0101);
    check("wrap_gnt2", 32'(gnt), 32'h4);
    step(1'b1, 4'b0101);
    check("wrap_gnt0b", 32'(gnt), 32'h1);

    // Reset pulse during continuous traffic
    step(1'b1, 4'b1010);
    step(1'b1, 4'b1010);
    step(1'b0, 4'b1010);
    check("midrst_gnt", 32'(gnt), 32'h0);
    check("midrst_q_vld", 32'(q_vld), 32'h0);
    step(1'b1, 4'b1010);
    check("midrst_regrant", 32'(gnt), 32'h2);

`ifdef RRARB_LOCK_EN
    // Locked owner gets MAX_LOCK+1 grants before forced release
    step(1'b0, 4'b0000);
    lock = 4'b0001;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 4'b0011);
      check("lock_gnt", 32'(gnt), (i == 9 || i == 19) ? 32'h2 : 32'h1);
    end
    lock = '0;
`endif

    // Random traffic, checked by the scoreboard only
    for (int i = 0; i < 60; i++) begin
      for (int j = 0; j < N; j++) wdata[j*W +: W] = W'($urandom);
`ifdef RRARB_LOCK_EN
      lock = N'($urandom);
`endif
      step(($urandom_range(0, 19) != 0), N'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
